// File: rtl/serial_compare_sequencer.sv
// serial_compare_sequencer: MSB-first 2-bit-slice magnitude compare with early exit on the first unequal slice
module serial_compare_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_a_gt_b,
  output logic             o_a_eq_b,
  output logic             o_a_lt_b,
  output logic [CNT_W-1:0] o_slice_cnt
);
  localparam int NS = WIDTH / 2;
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_slice_cnt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [1:0]       w_sa;
  logic [1:0]       w_sb;
  assign w_sa        = r_a[{r_p, 1'b0} +: 2];
  assign w_sb        = r_b[{r_p, 1'b0} +: 2];
  assign o_ready     = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_a_gt_b    = r_gt;
  assign o_a_eq_b    = r_eq;
  assign o_a_lt_b    = r_lt;
  assign o_slice_cnt = r_slice_cnt;
  // Sequencer: accept in IDLE, walk slices from the top in RUN, pulse done for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_slice_cnt <= '0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start && !i_abort) begin
          r_a     <= i_a;
          r_b     <= i_b;
          r_p     <= PW'(NS - 1);
          r_cnt   <= '0;
          r_gt    <= 1'b0;
          r_eq    <= 1'b0;
          r_lt    <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: if (i_abort) begin
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_sa != w_sb) begin
            r_gt        <= (w_sa > w_sb);
            r_lt        <= (w_sa < w_sb);
            r_slice_cnt <= r_cnt + CNT_W'(1);
            r_state     <= S_DONE;
          end else if (r_p == '0) begin
            r_eq        <= 1'b1;
            r_slice_cnt <= CNT_W'(NS);
            r_state     <= S_DONE;
          end else begin
            r_p <= r_p - PW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
